// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential signed 32x32->64 Booth multiplier, radix-4 when ALU_MUL_RADIX4_EN is defined
module alu_mul_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
`ifdef ALU_MUL_RADIX4_EN
  localparam int AW = 34, SH = 2, STEPS = 16;
`else
  localparam int AW = 33, SH = 1, STEPS = 32;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [AW-1:0] acc, m, sum;
  logic [31:0] q;
  logic q1;
  logic [4:0] cnt;
  logic [AW+32:0] shifted;
`ifdef ALU_MUL_RADIX4_EN
  logic [2:0] t;
  always_comb begin
    t = {q[1:0], q1};
    sum = (t == 3'b001 || t == 3'b010) ? acc + m :
          (t == 3'b011) ? acc + (m << 1) :
          (t == 3'b100) ? acc - (m << 1) :
          (t == 3'b101 || t == 3'b110) ? acc - m : acc;
    shifted = $signed({sum, q, q1}) >>> SH;
  end
`else
  always_comb begin
    sum = ({q[0], q1} == 2'b01) ? acc + m :
          ({q[0], q1} == 2'b10) ? acc - m : acc;
    shifted = $signed({sum, q, q1}) >>> SH;
  end
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      acc   <= '0;
      m     <= '0;
      q     <= '0;
      q1    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            m     <= {{(AW-32){a[31]}}, a};
            acc   <= '0;
            q     <= b;
            q1    <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc <= shifted[AW+32:33];
          q   <= shifted[32:1];
          q1  <= shifted[0];
          cnt <= cnt + 5'd1;
          if (cnt == 5'(STEPS-1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            hi    <= shifted[64:33];
            lo    <= shifted[32:1];
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Sequential signed 32×32→64 multiplier, the multiply counterpart of the ALU's restoring divider. It uses radix-2 Booth recoding, one step per clock, and returns the product split into `hi`/`lo` words in the same `{upper, lower}` layout as the divider's remainder/quotient pair. It sits beside the divider in the ALU and is driven by the control unit through a start/done handshake.

## Interface
- No parameters. Width is fixed at 32-bit operands and a 64-bit product.
- `clk`  in  1  — single clock, rising-edge.
- `reset`  in  1  — synchronous, active-high.
- `start`  in  1  — request a multiply. Accepted only in IDLE.
- `a`  in  32  — multiplicand, two's complement. Sampled on the accepting edge.
- `b`  in  32  — multiplier, two's complement. Sampled on the accepting edge.
- `busy`  out  1  — high while in RUN.
- `done`  out  1  — one-cycle pulse; `hi`/`lo` are valid in that cycle.
- `hi`  out  32  — product bits [63:32]. Registered.
- `lo`  out  32  — product bits [31:0]. Registered.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN when `start`=1.
  - Load M ← sign-extended `a` (33 bits).
  - Load A ← 0 (33 bits), Q ← `b`, q₋₁ ← 0, step counter ← 0.
- RUN, each cycle:
  - Examine {Q[0], q₋₁}: 01 → A ← A + M; 10 → A ← A − M; 00/11 → no change.
  - Then arithmetic right shift of {A, Q, q₋₁} by 1, with A[32] replicated.
  - Counter increments by 1.
  - After the 32nd step: go to DONE, load `hi` ← A[31:0] and `lo` ← Q.
- DONE → IDLE unconditionally after one cycle.
- A is 33 bits so that A − M cannot overflow when `a` = 0x80000000.
- The product is exact for all operand pairs, including −2³¹×−2³¹. There is no overflow flag.
- `start` in RUN or DONE is ignored: no restart and no queuing. The captured operands are unaffected by later changes on `a`/`b`.
- `hi`/`lo` hold the last product until the next product is written at the end of RUN. They do not change during RUN.
- `reset` (any state, including mid-RUN):
  - Next state is IDLE.
  - `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
  - The in-flight operation is discarded.
- Reset values: `busy`=0, `done`=0, `hi`=0x00000000, `lo`=0x00000000.

## Timing
- Edge E0: `start`=1 sampled in IDLE. `busy`=1 from E0 until E32.
- Edges E1..E32: Booth steps 1..32.
- After E32: state DONE, `busy`=0, `done`=1, product visible on `hi`/`lo`.
- After E33: state IDLE, `done`=0.
- Latency from start to done is 32 cycles. Start-to-start throughput is 34 cycles, because a `start` held high through DONE is accepted at E34.
- `busy` and `done` are never high in the same cycle.
- Reset asserted at edge Ek takes effect after Ek; the reset state holds while `reset` stays high.

## Configuration
- `ALU_MUL_RADIX4_EN` defined:
  - Radix-4 Booth. Examine {Q[1], Q[0], q₋₁} and add 0, ±M, or ±2M.
  - A widened to 34 bits; arithmetic shift by 2 per step; 16 steps.
  - `busy` for E0..E16, `done` after E16. Start-to-start is 18 cycles.
- Undefined: radix-2 behaviour as above, 32 steps.
- Products are identical in both builds. The bench reads latency from the macro.

## Test plan
- a=7, b=3, `start` pulse → `done` exactly 32 cycles later (16 if radix-4), `hi`=0x00000000, `lo`=0x00000015.
- a=−5 (0xFFFFFFFB), b=6 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFE2. Then a=0xFFFFFFFF, b=1 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFF.
- a=0x80000000, b=0x80000000 → `hi`=0x40000000, `lo`=0x00000000. a=0x7FFFFFFF, b=0x7FFFFFFF → `hi`=0x3FFFFFFF, `lo`=0x00000001.
- Start with a=2, b=3, then pulse `start` with a=9, b=9 at cycle 10 → result 6 (`lo`=0x00000006), a single `done` pulse, and `busy` remains continuous.
- Start with a=2, b=3, assert `reset` at cycle 10 for one cycle → next cycle `busy`=0, `hi`=`lo`=0, no `done`. A fresh start with a=4, b=4 yields `lo`=0x10 at the nominal latency.
- 1000 random signed pairs with back-to-back starts held high → every result matches the 64-bit reference product, and `hi`/`lo` are stable while `busy`=1.
